max_pool_stage: RTL and testbench

- Downstream of the convolution layer: 2x2, stride-2 max-pool over one finished conv output channel (H x W signed 8-bit values, row-major).
- Reads the channel from the result register file through a 1-cycle-latency read port and writes the pooled (H/2) x (W/2) map to the pooled-feature buffer.
- Optional ReLU is applied on the write path.
- Started once per output channel by top control (pool); reports completion on done (consumed as pool_done).

---
 rtl/pool_pkg.sv | 38 +++
 rtl/pool_addr_gen.sv | 61 ++++++
 rtl/max_pool_stage.sv | 150 +++++++++++++++
 tb/tb_max_pool_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 / stride-2 max-pool stage: default
// geometry, FSM state encoding and window address helpers.
package pool_pkg;

    // Default channel geometry (28x28 conv output) and the pooled map it yields.
    localparam int H_DEF = 28;
    localparam int W_DEF = 28;
    localparam int OH    = H_DEF / 2;
    localparam int OW    = W_DEF / 2;
    localparam int NWIN  = OH * OW;

    // FSM state encoding, kept as plain constants for legacy tool flows.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_RD0  = 3'd1;
    localparam state_t S_RD1  = 3'd2;
    localparam state_t S_RD2  = 3'd3;
    localparam state_t S_RD3  = 3'd4;
    localparam state_t S_CAP  = 3'd5;
    localparam state_t S_WR   = 3'd6;
    localparam state_t S_DONE = 3'd7;

    // Offset of the idx-th window element from the window base: {0, 1, W, W+1}.
    function automatic int win_offset(input int idx, input int w);
        case (idx)
            0:       return 0;
            1:       return 1;
            2:       return w;
            default: return w + 1;
        endcase
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window walker for the max-pool stage: row/column/output counters plus a
// running window base address, advanced once per window by the FSM.
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int H   = H_DEF,
    parameter int W   = W_DEF,
    parameter int AW  = 10,
    parameter int OAW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           step,
    output logic [AW-1:0]  base,
    output logic [OAW-1:0] out_idx,
    output logic           last
);

    localparam int OUT_H = H / 2;
    localparam int OUT_W = W / 2;
    localparam int RW    = cnt_width(OUT_H);
    localparam int CWD   = cnt_width(OUT_W);

    // Moving one window right adds 2; wrapping to the next window row jumps
    // from 2r*W + 2(OUT_W-1) to 2(r+1)*W. With odd W this skips the
    // trailing column, which is never read.
    localparam logic [AW-1:0] COL_STEP = AW'(2);
    localparam logic [AW-1:0] ROW_STEP = AW'(2 * W - 2 * OUT_W + 2);

    logic [RW-1:0]  r;
    logic [CWD-1:0] c;

    // Counters clear on start and advance once per window on step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r       <= '0;
            c       <= '0;
            base    <= '0;
            out_idx <= '0;
        end else if (clear) begin
            r       <= '0;
            c       <= '0;
            base    <= '0;
            out_idx <= '0;
        end else if (step) begin
            out_idx <= out_idx + OAW'(1);
            if (c == CWD'(OUT_W - 1)) begin
                c    <= '0;
                r    <= r + RW'(1);
                base <= base + ROW_STEP;
            end else begin
                c    <= c + CWD'(1);
                base <= base + COL_STEP;
            end
        end
    end

    assign last = (r == RW'(OUT_H - 1)) && (c == CWD'(OUT_W - 1));

endmodule

// File: rtl/max_pool_stage.sv
// 2x2, stride-2 max-pool over one conv output channel. Reads four values per
// window through a 1-cycle-latency port, keeps a signed running max, and
// writes the (optionally ReLU-clamped) result to the pooled-feature buffer.
module max_pool_stage
    import pool_pkg::*;
#(
    parameter int H    = H_DEF,
    parameter int W    = W_DEF,
    parameter int DW   = 8,
    parameter int AW   = 10,
    parameter int OAW  = 8,
    parameter int CW   = 4,
    parameter int RELU = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [CW-1:0]  ch,
    output logic           busy,
    output logic           done,
    output logic           rd_en,
    output logic [AW-1:0]  rd_addr,
    input  logic [DW-1:0]  rd_data,
    output logic           wr_en,
    output logic [CW-1:0]  wr_ch,
    output logic [OAW-1:0] wr_addr,
    output logic [DW-1:0]  wr_data
);

    localparam logic [AW-1:0] OFF_1 = AW'(win_offset(1, W));
    localparam logic [AW-1:0] OFF_2 = AW'(win_offset(2, W));
    localparam logic [AW-1:0] OFF_3 = AW'(win_offset(3, W));

    state_t                state;
    logic signed [DW-1:0]  max_q;
    logic signed [DW-1:0]  rd_s;
    logic signed [DW-1:0]  max_next;
    logic signed [DW-1:0]  wr_val;
    logic                  last_win;

    logic [AW-1:0]         base;
    logic [OAW-1:0]        out_idx;
    logic                  last;
    logic                  accept;
    logic                  step;

    assign accept = (state == S_IDLE) && start;
    // Counters advance while the window's write data is being captured, so
    // the next base is ready when WR hands over to RD0.
    assign step   = (state == S_CAP);

    pool_addr_gen #(
        .H   (H),
        .W   (W),
        .AW  (AW),
        .OAW (OAW)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .step    (step),
        .base    (base),
        .out_idx (out_idx),
        .last    (last)
    );

    // Strict greater-than keeps the held value on ties.
    assign rd_s     = signed'(rd_data);
    assign max_next = (rd_s > max_q) ? rd_s : max_q;
    assign wr_val   = ((RELU != 0) && max_next[DW-1]) ? '0 : max_next;

    // Sequencer: four reads, capture of the last read, one write per window.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            wr_en    <= 1'b0;
            wr_ch    <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            max_q    <= '0;
            last_win <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        wr_ch   <= ch;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        state   <= S_RD0;
                    end
                end
                S_RD0: begin
                    rd_addr <= base + OFF_1;
                    state   <= S_RD1;
                end
                S_RD1: begin
                    max_q   <= rd_s;
                    rd_addr <= base + OFF_2;
                    state   <= S_RD2;
                end
                S_RD2: begin
                    max_q   <= max_next;
                    rd_addr <= base + OFF_3;
                    state   <= S_RD3;
                end
                S_RD3: begin
                    max_q <= max_next;
                    rd_en <= 1'b0;
                    state <= S_CAP;
                end
                S_CAP: begin
                    max_q    <= max_next;
                    wr_en    <= 1'b1;
                    wr_addr  <= out_idx;
                    wr_data  <= wr_val;
                    last_win <= last;
                    state    <= S_WR;
                end
                S_WR: begin
                    wr_en <= 1'b0;
                    if (last_win) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        rd_en   <= 1'b1;
                        rd_addr <= base;
                        state   <= S_RD0;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_pool_stage.sv
// Self-checking bench for max_pool_stage: a 28x28 ReLU instance and a 5x5
// pass-through instance, each fed from a 1-cycle-latency memory model.
`timescale 1ns/1ps
module tb_max_pool_stage;
    import pool_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 28x28, RELU=1
    logic       start_a;
    logic [3:0] ch_a;
    logic       busy_a, done_a, rd_en_a, wr_en_a;
    logic [9:0] rd_addr_a;
    logic [7:0] rd_data_a;
    logic [3:0] wr_ch_a;
    logic [7:0] wr_addr_a, wr_data_a;

    // 5x5, RELU=0
    logic       start_b;
    logic [3:0] ch_b;
    logic       busy_b, done_b, rd_en_b, wr_en_b;
    logic [9:0] rd_addr_b;
    logic [7:0] rd_data_b;
    logic [3:0] wr_ch_b;
    logic [7:0] wr_addr_b, wr_data_b;

    max_pool_stage #(.H(28), .W(28), .RELU(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .ch(ch_a), .busy(busy_a),
        .done(done_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .wr_en(wr_en_a), .wr_ch(wr_ch_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
    );

    max_pool_stage #(.H(5), .W(5), .RELU(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .ch(ch_b), .busy(busy_b),
        .done(done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .wr_en(wr_en_b), .wr_ch(wr_ch_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
    );

    logic [7:0] mem_a [0:783];
    logic [7:0] mem_b [0:24];
    logic [7:0] cap_a [0:255];
    logic [7:0] cap_b [0:255];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0_a = 0;
    int exp_ch_a = 0;

    int wr_cnt_a, rd_cnt_a, done_cnt_a, ch_bad_a;
    int first_addr_a, first_wr_idx_a, last_wr_idx_a, done_idx_a;
    int wr_cnt_b, rd_cnt_b, done_cnt_b, bad_rd_b;
    int rd_base_b [4];

    typedef struct {
        int v [4];
        int exp_relu;
        int exp_pass;
    } win_vec_t;
    win_vec_t tbl [4];

    always @(posedge clk) cyc <= cyc + 1;

    // Result register file models: data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= (rd_addr_a < 10'd784) ? mem_a[rd_addr_a] : 8'h00;
        if (rd_en_b) rd_data_b <= (rd_addr_b < 10'd25) ? mem_b[rd_addr_b] : 8'h00;
    end

    // Output monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en_a) begin
            if (wr_cnt_a == 0) first_addr_a = int'(wr_addr_a);
            if (first_wr_idx_a < 0) first_wr_idx_a = cyc - t0_a;
            last_wr_idx_a = cyc - t0_a;
            cap_a[wr_addr_a] = wr_data_a;
            if (int'(wr_ch_a) != exp_ch_a) ch_bad_a++;
            wr_cnt_a++;
        end
        if (rd_en_a) rd_cnt_a++;
        if (done_a) begin
            done_cnt_a++;
            done_idx_a = cyc - t0_a;
        end
        if (wr_en_b) begin
            cap_b[wr_addr_b] = wr_data_b;
            wr_cnt_b++;
        end
        if (rd_en_b) begin
            if ((rd_cnt_b % 4 == 0) && (rd_cnt_b / 4 < 4)) rd_base_b[rd_cnt_b / 4] = int'(rd_addr_b);
            if ((int'(rd_addr_b) % 5 == 4) || (int'(rd_addr_b) >= 20)) bad_rd_b++;
            rd_cnt_b++;
        end
        if (done_b) done_cnt_b++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_a();
        wr_cnt_a = 0; rd_cnt_a = 0; done_cnt_a = 0; ch_bad_a = 0;
        first_addr_a = -1; first_wr_idx_a = -1; last_wr_idx_a = -1; done_idx_a = -1;
    endtask

    // Called mid-cycle; start is accepted at the next edge (cycle index 0).
    task automatic go_a(input int c);
        clear_a();
        exp_ch_a = c;
        ch_a     = 4'(c);
        start_a  = 1'b1;
        t0_a     = cyc;
        tick();
        start_a  = 1'b0;
    endtask

    task automatic wait_done_a(input string name, input int budget);
        int n = 0;
        while (done_cnt_a == 0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_finished"}, int'(done_cnt_a > 0), 1);
    endtask

    // Independent reference: max of the 2x2 window at row r, column c.
    function automatic int model_a(input int k);
        int r = k / 14;
        int c = k % 14;
        int b = 2 * r * 28 + 2 * c;
        int m = int'($signed(mem_a[b]));
        int addrs [3] = '{b + 1, b + 28, b + 29};
        for (int j = 0; j < 3; j++)
            if (int'($signed(mem_a[addrs[j]])) > m) m = int'($signed(mem_a[addrs[j]]));
        return (m < 0) ? 0 : m;
    endfunction

    initial begin
        int saved;
        int bases_b [4] = '{0, 2, 10, 12};
        int n;

        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; ch_a = '0; ch_b = '0;
        rd_data_a = '0; rd_data_b = '0;
        clear_a();
        wr_cnt_b = 0; rd_cnt_b = 0; done_cnt_b = 0; bad_rd_b = 0;
        for (int i = 0; i < 784; i++) mem_a[i] = 8'(i % 128);
        for (int i = 0; i < 25; i++)  mem_b[i] = 8'd127;

        tbl[0].v = '{-5, -9, -1, -128};      tbl[0].exp_relu = 0;   tbl[0].exp_pass = -1;
        tbl[1].v = '{-128, 127, 0, 5};       tbl[1].exp_relu = 127; tbl[1].exp_pass = 127;
        tbl[2].v = '{7, 7, 7, 7};            tbl[2].exp_relu = 7;   tbl[2].exp_pass = 7;
        tbl[3].v = '{-128, -128, -128, -128}; tbl[3].exp_relu = 0;  tbl[3].exp_pass = -128;

        // Reset state
        repeat (2) tick();
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_rd_en", int'(rd_en_a), 0);
        check("rst_wr_en", int'(wr_en_a), 0);
        check("rst_rd_addr", int'(rd_addr_a), 0);
        check("rst_wr_addr", int'(wr_addr_a), 0);
        check("rst_wr_data", int'(wr_data_a), 0);
        check("rst_wr_ch", int'(wr_ch_a), 0);
        rst = 1'b1;
        repeat (2) tick();

        // Ramp run on the 28x28 instance
        go_a(3);
        check("ramp_busy_cycle1", int'(busy_a), 1);
        wait_done_a("ramp", 1400);
        repeat (2) tick();
        check("ramp_writes", wr_cnt_a, NWIN);
        check("ramp_addr0", int'($signed(cap_a[0])), 29);
        check("ramp_addr195", int'($signed(cap_a[195])), 115);
        for (int k = 0; k < 196; k++)
            check($sformatf("ramp_win%0d", k), int'($signed(cap_a[k])), model_a(k));
        check("ramp_first_wr_cycle", first_wr_idx_a, 6);
        check("ramp_last_wr_cycle", last_wr_idx_a, 1176);
        check("ramp_done_cycle", done_idx_a, 1177);
        check("ramp_done_count", done_cnt_a, 1);
        check("ramp_rd_count", rd_cnt_a, 784);
        check("ramp_wr_ch_bad", ch_bad_a, 0);
        check("ramp_busy_after", int'(busy_a), 0);

        // Table-driven windows: row 0 of the 28x28 map and all of the 5x5 map
        for (int k = 0; k < 4; k++) begin
            mem_a[2 * k]      = 8'(tbl[k].v[0]);
            mem_a[2 * k + 1]  = 8'(tbl[k].v[1]);
            mem_a[2 * k + 28] = 8'(tbl[k].v[2]);
            mem_a[2 * k + 29] = 8'(tbl[k].v[3]);
            mem_b[bases_b[k]]     = 8'(tbl[k].v[0]);
            mem_b[bases_b[k] + 1] = 8'(tbl[k].v[1]);
            mem_b[bases_b[k] + 5] = 8'(tbl[k].v[2]);
            mem_b[bases_b[k] + 6] = 8'(tbl[k].v[3]);
        end
        go_a(5);
        wait_done_a("table_a", 1400);
        ch_b = 4'd1; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (done_cnt_b == 0 && n < 100) begin
            tick();
            n++;
        end
        check("table_b_finished", int'(done_cnt_b > 0), 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("tbl%0d_relu", k), int'($signed(cap_a[k])), tbl[k].exp_relu);
            check($sformatf("tbl%0d_pass", k), int'($signed(cap_b[k])), tbl[k].exp_pass);
            check($sformatf("b_base%0d", k), rd_base_b[k], bases_b[k]);
        end
        check("b_writes", wr_cnt_b, 4);
        check("b_reads", rd_cnt_b, 16);
        check("b_bad_reads", bad_rd_b, 0);
        check("b_wr_ch", int'(wr_ch_b), 1);

        // start held high across a whole run, re-pulsed mid-run
        tick();
        clear_a();
        exp_ch_a = 4; ch_a = 4'd4; start_a = 1'b1; t0_a = cyc;
        n = 0;
        while (!done_a && n < 1400) begin
            tick();
            n++;
            if (cyc - t0_a == 500) start_a = 1'b0;
            if (cyc - t0_a == 501) start_a = 1'b1;
        end
        check("hold_reached_done", int'(done_a), 1);
        check("hold_busy_in_done", int'(busy_a), 0);
        check("hold_writes", wr_cnt_a, 196);
        check("hold_last_wr_cycle", last_wr_idx_a, 1176);
        tick();
        check("hold_done_count", done_cnt_a, 1);
        check("hold_busy_idle", int'(busy_a), 0);
        tick();
        // start still high in the cycle after done: second run accepted
        start_a = 1'b0;
        check("rerun_busy", int'(busy_a), 1);
        clear_a();
        t0_a = cyc - 1;
        wait_done_a("rerun", 1400);
        check("rerun_writes", wr_cnt_a, 196);
        check("rerun_first_addr", first_addr_a, 0);
        check("rerun_first_wr_cycle", first_wr_idx_a, 6);

        // Asynchronous reset during cycle 300 (a write cycle)
        repeat (2) tick();
        go_a(7);
        n = 0;
        while ((cyc - t0_a) < 300 && n < 400) begin
            tick();
            n++;
        end
        check("abort_wr_en_before", int'(wr_en_a), 1);
        rst = 1'b0;
        #1;
        check("abort_busy", int'(busy_a), 0);
        check("abort_wr_en", int'(wr_en_a), 0);
        check("abort_rd_en", int'(rd_en_a), 0);
        saved = wr_cnt_a;
        repeat (5) tick();
        check("abort_writes", saved, 49);
        check("abort_no_more_writes", wr_cnt_a, saved);
        check("abort_no_done", done_cnt_a, 0);
        rst = 1'b1;
        repeat (2) tick();
        go_a(2);
        wait_done_a("post_abort", 1400);
        check("post_abort_writes", wr_cnt_a, 196);
        check("post_abort_first_addr", first_addr_a, 0);
        check("post_abort_wr_ch_bad", ch_bad_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout expected completion");
        $fatal(1, "simulation did not finish");
    end

endmodule
